frame_rx_crc: RTL and testbench

Parametrised byte-stream frame receiver that replaces the fixed 16-byte receive path.
- Collects N_BYTES bytes MSB-first; the last CRC_W/8 bytes are the frame CRC.
- Computes the CRC incrementally, one byte per accepted cycle, checks it, and presents the payload on a valid/ready output handshake.
- Sits between the UART byte deserialiser and the AES decrypt core.

---
 rtl/frame_rx_pkg.sv | 14 +
 rtl/crc_byte_update.sv | 21 ++
 rtl/frame_rx_crc.sv | 144 ++++++++++++++
 tb/tb_frame_rx_crc.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_rx_pkg.sv
// Shared types and default CRC constants for the frame receiver.
package frame_rx_pkg;

  typedef enum logic [1:0] {
    COLLECT,
    CHECK,
    HOLD
  } state_e;

  localparam logic [15:0] CRC16_CCITT_POLY = 16'h1021;
  localparam logic [15:0] CRC16_CCITT_INIT = 16'hFFFF;
  localparam logic [7:0]  CRC8_POLY        = 8'h07;

endpackage

// File: rtl/crc_byte_update.sv
// One-byte MSB-first, non-reflected CRC step, unrolled over the 8 input bits.
module crc_byte_update #(
  parameter int               CRC_W    = 16,
  parameter logic [CRC_W-1:0] CRC_POLY = CRC_W'(16'h1021)
) (
  input  logic [CRC_W-1:0] crc_in,
  input  logic [7:0]       byte_in,
  output logic [CRC_W-1:0] crc_out
);

  logic [CRC_W-1:0] w_crc;

  always_comb begin
    w_crc = crc_in ^ (CRC_W'(byte_in) << (CRC_W - 8));
    for (int i = 0; i < 8; i++) begin
      w_crc = w_crc[CRC_W-1] ? ((w_crc << 1) ^ CRC_POLY) : (w_crc << 1);
    end
    crc_out = w_crc;
  end

endmodule

// File: rtl/frame_rx_crc.sv
// Byte-stream frame receiver with incremental CRC check and valid/ready output.
// Optional inter-byte idle timeout enabled by defining RX_TIMEOUT_EN.
//
// state   | meaning
// COLLECT | accepting frame bytes, CRC updated per payload byte
// CHECK   | compare computed vs received CRC, load output register
// HOLD    | frame presented; waits for out_ready
module frame_rx_crc
  import frame_rx_pkg::*;
#(
  parameter int               N_BYTES        = 16,
  parameter int               CRC_W          = 16,
  parameter logic [CRC_W-1:0] CRC_POLY       = CRC_W'(CRC16_CCITT_POLY),
  parameter logic [CRC_W-1:0] CRC_INIT       = CRC_W'(CRC16_CCITT_INIT),
  parameter int               TIMEOUT_CYCLES = 1024
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [7:0]                         rx_data,
  input  logic                               rx_valid,
  input  logic                               crc_en,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [(N_BYTES-CRC_W/8)*8-1:0]     data_out,
  output logic                               crc_err,
  output logic                               overrun,
  output logic                               frame_drop
);

  localparam int PAY_B = N_BYTES - CRC_W / 8;
  localparam int PAY_W = PAY_B * 8;
  localparam int CNT_W = $clog2(N_BYTES + 1);
  localparam logic [CNT_W-1:0] PAY_CNT  = CNT_W'(PAY_B);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_BYTES - 1);

  state_e             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_byte_cnt, w_cnt_base;
  logic [CRC_W-1:0]   r_crc, r_rx_crc, w_crc_base, w_crc_next;
  logic [PAY_W-1:0]   r_shift, r_data_out;
  logic               r_out_valid, r_crc_err, r_overrun;
  logic               w_restart, w_accept, w_is_pay, w_last, w_timeout;

  // Releasing a held frame and taking byte 0 of the next one can share a cycle
  assign w_restart  = (r_state == HOLD) && out_ready;
  assign w_accept   = rx_valid && ((r_state == COLLECT) || w_restart);
  assign w_cnt_base = w_restart ? '0 : r_byte_cnt;
  assign w_crc_base = w_restart ? CRC_INIT : r_crc;
  assign w_is_pay   = w_cnt_base < PAY_CNT;
  assign w_last     = w_accept && (w_cnt_base == LAST_CNT);

  crc_byte_update #(
    .CRC_W   (CRC_W),
    .CRC_POLY(CRC_POLY)
  ) u_crc (
    .crc_in (w_crc_base),
    .byte_in(rx_data),
    .crc_out(w_crc_next)
  );

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      COLLECT: if (w_last) w_state_nxt = CHECK;
      CHECK:   w_state_nxt = HOLD;
      HOLD:    if (out_ready) w_state_nxt = COLLECT;
      default: w_state_nxt = COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= COLLECT;
    else        r_state <= w_state_nxt;
  end

`ifdef RX_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LOAD = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] r_idle_cnt;
  logic            r_frame_drop;

  // A byte arriving on the expiry cycle keeps the frame alive
  assign w_timeout = (r_state == COLLECT) && (r_byte_cnt != '0) && !rx_valid &&
                     (r_idle_cnt == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_idle_cnt   <= TO_LOAD;
      r_frame_drop <= 1'b0;
    end else begin
      r_frame_drop <= w_timeout;
      if (rx_valid || w_timeout)
        r_idle_cnt <= TO_LOAD;
      else if ((r_state == COLLECT) && (r_byte_cnt != '0))
        r_idle_cnt <= r_idle_cnt - TO_W'(1);
    end
  end

  assign frame_drop = r_frame_drop;
`else
  assign w_timeout  = 1'b0;
  assign frame_drop = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_byte_cnt  <= '0;
      r_crc       <= CRC_INIT;
      r_rx_crc    <= '0;
      r_shift     <= '0;
      r_data_out  <= '0;
      r_out_valid <= 1'b0;
      r_crc_err   <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_overrun <= rx_valid && !w_accept;
      if (w_accept) begin
        r_byte_cnt <= w_cnt_base + CNT_W'(1);
        if (w_is_pay) begin
          r_shift <= (r_shift << 8) | PAY_W'(rx_data);
          r_crc   <= w_crc_next;
        end else begin
          r_rx_crc <= (r_rx_crc << 8) | CRC_W'(rx_data);
        end
      end else if (w_restart || w_timeout) begin
        r_byte_cnt <= '0;
        r_crc      <= CRC_INIT;
      end
      if (r_state == CHECK) begin
        r_crc_err   <= crc_en && (r_crc != r_rx_crc);
        r_data_out  <= r_shift;
        r_out_valid <= 1'b1;
      end else if (w_restart) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign data_out  = r_data_out;
  assign crc_err   = r_crc_err;
  assign overrun   = r_overrun;

endmodule

// File: tb/tb_frame_rx_crc.sv
// Self-checking bench for frame_rx_crc: vector table, scoreboard queues, corner sequences.
module tb_frame_rx_crc;

  logic clk = 1'b0;
  logic reset;
  logic [7:0] rx_data;
  logic crc_en, out_ready;
  logic vld_a, vld_b, vld_c;

  logic a_valid, a_err, a_ovr, a_drop;
  logic b_valid, b_err, b_ovr, b_drop;
  logic c_valid, c_err, c_ovr, c_drop;
  logic [71:0]  a_data, b_data;
  logic [111:0] c_data;

  int n_tests = 0;
  int n_fail  = 0;
  int ovr_c   = 0;
  int ovr_ab  = 0;
  int drop_abc = 0;

  typedef struct {
    logic [111:0] data;
    logic         err;
  } exp_t;

  typedef struct {
    int           inst;
    logic [127:0] fr;
    int           nb;
    logic         en;
    logic [111:0] exp_data;
    logic         exp_err;
  } vec_t;

  exp_t q_a[$], q_b[$], q_c[$];
  vec_t vecs[6];

  always #5 clk = ~clk;

  frame_rx_crc #(.N_BYTES(11), .CRC_W(16)) u_a (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(vld_a), .crc_en(crc_en),
    .out_valid(a_valid), .out_ready(out_ready), .data_out(a_data), .crc_err(a_err),
    .overrun(a_ovr), .frame_drop(a_drop));

  frame_rx_crc #(.N_BYTES(10), .CRC_W(8), .CRC_POLY(8'h07), .CRC_INIT(8'h00)) u_b (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(vld_b), .crc_en(crc_en),
    .out_valid(b_valid), .out_ready(out_ready), .data_out(b_data), .crc_err(b_err),
    .overrun(b_ovr), .frame_drop(b_drop));

  frame_rx_crc u_c (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(vld_c), .crc_en(crc_en),
    .out_valid(c_valid), .out_ready(out_ready), .data_out(c_data), .crc_err(c_err),
    .overrun(c_ovr), .frame_drop(c_drop));

`ifdef RX_TIMEOUT_EN
  logic vld_d, d_valid, d_err, d_ovr, d_drop;
  logic [111:0] d_data;
  exp_t q_d[$];
  int drop_d = 0;

  frame_rx_crc #(.TIMEOUT_CYCLES(8)) u_d (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(vld_d), .crc_en(crc_en),
    .out_valid(d_valid), .out_ready(out_ready), .data_out(d_data), .crc_err(d_err),
    .overrun(d_ovr), .frame_drop(d_drop));
`endif

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    n_tests++;
    n_fail++;
    $display("FAIL %s: unexpected out_valid handshake, scoreboard empty", nm);
  endtask

  // Serial LFSR reference: feedback = register MSB xor incoming bit
  function automatic logic [31:0] tb_crc(input logic [127:0] fr, input int nb, input int w,
                                         input logic [31:0] poly, input logic [31:0] init);
    logic [31:0] c, mask;
    logic [7:0]  bv;
    logic        fb;
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
    c = init & mask;
    for (int i = 0; i < nb; i++) begin
      bv = fr[127-8*i -: 8];
      for (int b = 7; b >= 0; b--) begin
        fb = c[w-1] ^ bv[b];
        c  = (c << 1) & mask;
        if (fb) c = c ^ (poly & mask);
      end
    end
    return c;
  endfunction

  function automatic logic [127:0] mk16(input logic [111:0] pay);
    logic [31:0] c;
    c = tb_crc({pay, 16'h0}, 14, 16, 32'h1021, 32'hFFFF);
    return {pay, c[15:0]};
  endfunction

  task automatic send_byte(input int inst, input logic [7:0] b);
    rx_data = b;
    vld_a = (inst == 0);
    vld_b = (inst == 1);
    vld_c = (inst == 2);
`ifdef RX_TIMEOUT_EN
    vld_d = (inst == 3);
`endif
    @(posedge clk); #1;
    vld_a = 1'b0;
    vld_b = 1'b0;
    vld_c = 1'b0;
`ifdef RX_TIMEOUT_EN
    vld_d = 1'b0;
`endif
  endtask

  task automatic send_frame(input int inst, input logic [127:0] fr, input int first, input int last);
    for (int i = first; i <= last; i++) send_byte(inst, fr[127-8*i -: 8]);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // Scoreboard monitors: pop on each completed output handshake
  always @(negedge clk) begin
    exp_t e;
    if (reset && a_valid && out_ready) begin
      if (q_a.size() == 0) fail_now("a_pop");
      else begin
        e = q_a.pop_front();
        chk("a_data", 128'(a_data), 128'(e.data));
        chk("a_crc_err", 128'(a_err), 128'(e.err));
      end
    end
    if (reset && b_valid && out_ready) begin
      if (q_b.size() == 0) fail_now("b_pop");
      else begin
        e = q_b.pop_front();
        chk("b_data", 128'(b_data), 128'(e.data));
        chk("b_crc_err", 128'(b_err), 128'(e.err));
      end
    end
    if (reset && c_valid && out_ready) begin
      if (q_c.size() == 0) fail_now("c_pop");
      else begin
        e = q_c.pop_front();
        chk("c_data", 128'(c_data), 128'(e.data));
        chk("c_crc_err", 128'(c_err), 128'(e.err));
      end
    end
`ifdef RX_TIMEOUT_EN
    if (reset && d_valid && out_ready) begin
      if (q_d.size() == 0) fail_now("d_pop");
      else begin
        e = q_d.pop_front();
        chk("d_data", 128'(d_data), 128'(e.data));
        chk("d_crc_err", 128'(d_err), 128'(e.err));
      end
    end
    if (d_drop) drop_d++;
`endif
    if (c_ovr) ovr_c++;
    if (a_ovr || b_ovr) ovr_ab++;
    if (a_drop || b_drop || c_drop) drop_abc++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] f1, f2, f3;
    int k;
    exp_t e;

    vecs[0] = '{0, {88'h31323334353637383929B1, 40'h0}, 11, 1'b1, 112'h313233343536373839, 1'b0};
    vecs[1] = '{0, {88'h31323334353637383929B0, 40'h0}, 11, 1'b1, 112'h313233343536373839, 1'b1};
    vecs[2] = '{0, {88'h31323334353637383929B0, 40'h0}, 11, 1'b0, 112'h313233343536373839, 1'b0};
    vecs[3] = '{0, {88'h31323334353637383929B1, 40'h0}, 11, 1'b0, 112'h313233343536373839, 1'b0};
    vecs[4] = '{1, {80'h313233343536373839F4, 48'h0}, 10, 1'b1, 112'h313233343536373839, 1'b0};
    vecs[5] = '{1, {80'h313233343536373839F5, 48'h0}, 10, 1'b1, 112'h313233343536373839, 1'b1};

    reset = 1'b0; rx_data = '0; crc_en = 1'b1; out_ready = 1'b1;
    vld_a = 1'b0; vld_b = 1'b0; vld_c = 1'b0;
`ifdef RX_TIMEOUT_EN
    vld_d = 1'b0;
`endif
    repeat (2) @(negedge clk);
    chk("rst_a_valid", 128'(a_valid), 128'd0);
    chk("rst_c_data", 128'(c_data), 128'd0);
    chk("rst_c_err", 128'(c_err), 128'd0);
    chk("rst_c_overrun", 128'(c_ovr), 128'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    idle(2);

    // Table-driven frames on the 11-byte CRC16 and 10-byte CRC8 instances
    for (int v = 0; v < 6; v++) begin
      crc_en = vecs[v].en;
      e.data = vecs[v].exp_data;
      e.err  = vecs[v].exp_err;
      if (vecs[v].inst == 0) q_a.push_back(e);
      else                   q_b.push_back(e);
      send_frame(vecs[v].inst, vecs[v].fr, 0, vecs[v].nb - 1);
      idle(4);
    end
    crc_en = 1'b1;

    // Held frame drops bytes with overrun; restart byte on release is kept
    out_ready = 1'b0;
    f1 = mk16(112'h0102030405060708090a0b0c0d0e);
    e.data = f1[127:16]; e.err = 1'b0; q_c.push_back(e);
    send_frame(2, f1, 0, 15);
    k = 0;
    while (!c_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("c_valid_wait", 128'(c_valid), 128'd1);
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      send_byte(2, 8'h55);
      idle(1);
      chk("c_hold_data", 128'(c_data), 128'(f1[127:16]));
      chk("c_hold_valid", 128'(c_valid), 128'd1);
    end
    chk("c_overrun_cnt", 128'(ovr_c), 128'd3);
    out_ready = 1'b1;
    f2 = mk16({8'hAA, 104'h1112131415161718191a1b1c1d});
    e.data = f2[127:16]; e.err = 1'b0; q_c.push_back(e);
    send_frame(2, f2, 0, 15);
    idle(4);
    chk("c_overrun_after_restart", 128'(ovr_c), 128'd3);
    chk("c_restart_top_byte", 128'(c_data[111:104]), 128'hAA);

    // Reset mid-frame discards the partial frame silently
    send_frame(2, f1, 0, 6);
    reset = 1'b0;
    @(negedge clk);
    chk("c_midrst_valid", 128'(c_valid), 128'd0);
    chk("c_midrst_overrun", 128'(c_ovr), 128'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    idle(1);
    f3 = mk16(112'h1d5a6621527f5b226bf0e97205a6);
    e.data = f3[127:16]; e.err = 1'b0; q_c.push_back(e);
    send_frame(2, f3, 0, 15);
    idle(4);

`ifdef RX_TIMEOUT_EN
    f1 = mk16(112'hc0c1c2c3c4c5c6c7c8c9cacbcccd);
    send_frame(3, f1, 0, 4);
    idle(7);
    chk("d_no_drop_before_8", 128'(drop_d), 128'd0);
    idle(3);
    chk("d_drop_after_8", 128'(drop_d), 128'd1);
    e.data = f1[127:16]; e.err = 1'b0; q_d.push_back(e);
    send_frame(3, f1, 0, 15);
    idle(4);
    f2 = mk16(112'hd0d1d2d3d4d5d6d7d8d9dadbdcdd);
    e.data = f2[127:16]; e.err = 1'b0; q_d.push_back(e);
    send_frame(3, f2, 0, 4);
    idle(7);
    send_frame(3, f2, 5, 15);
    idle(4);
    chk("d_no_drop_byte_on_8", 128'(drop_d), 128'd1);
    chk("d_queue_empty", 128'(q_d.size()), 128'd0);
`endif

    chk("a_queue_empty", 128'(q_a.size()), 128'd0);
    chk("b_queue_empty", 128'(q_b.size()), 128'd0);
    chk("c_queue_empty", 128'(q_c.size()), 128'd0);
    chk("ab_no_overrun", 128'(ovr_ab), 128'd0);
    chk("abc_no_frame_drop", 128'(drop_abc), 128'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
